// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared types and default geometry for the register file
package register_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 8;

endpackage

// File: rtl/register_file_clear_fsm.sv
// rtl/register_file_clear_fsm.sv - clear engine: walks every address once, zeroing it
module register_file_clear_fsm
  import register_file_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  clr_en,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        // Counter wraps back to zero on the last address, ready for the next clear.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == CLEAR);
  assign clr_en   = (state_q == CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - two-read/one-write register file with hardware clear engine
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter bit WRITE_FIRST = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear_req,
  output logic                  busy,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] read_addr_a,
  output logic [DATA_WIDTH-1:0] data_out_a,
  input  logic [ADDR_WIDTH-1:0] read_addr_b,
  output logic [DATA_WIDTH-1:0] data_out_b
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
  logic                  clr_en, user_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  register_file_clear_fsm #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear_fsm (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear_req (clear_req),
    .busy      (busy),
    .clr_en    (clr_en),
    .clr_addr  (clr_addr)
  );

  // A user write coinciding with clear_req is dropped rather than racing the clear.
  assign user_we = write_en && !clr_en && !clear_req;

  always_ff @(posedge clock) begin
    if (clr_en) mem_q[clr_addr] <= '0;
    else if (user_we) mem_q[write_addr] <= data_in;
  end

  always_comb begin
    data_a_d = mem_q[read_addr_a];
    data_b_d = mem_q[read_addr_b];
    if (WRITE_FIRST && user_we && (write_addr == read_addr_a)) data_a_d = data_in;
    if (WRITE_FIRST && user_we && (write_addr == read_addr_b)) data_b_d = data_in;
    if (clr_en) begin
      data_a_d = '0;
      data_b_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end

  assign data_out_a = data_a_q;
  assign data_out_b = data_b_q;

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - randomized bench for register_file against a behavioural model
module tb_register_file;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       creq = 1'b0, wen = 1'b0;
  logic [7:0] wa = '0, din = '0, ra = '0, rb = '0;
  logic       busy_wf, busy_rf;
  logic [7:0] da_wf, db_wf, da_rf, db_rf;

  logic        s_creq = 1'b0, s_we = 1'b0;
  logic [3:0]  s_wa = '0, s_ra = '0, s_rb = '0;
  logic [15:0] s_din = '0, s_da, s_db;
  logic        s_busy;

  int checks = 0, failures = 0;

  // behavioural model: remaining clear edges plus flat memory image
  int         clr_left;
  logic [7:0] m [256];
  logic       e_busy;
  logic [7:0] e_a1, e_b1, e_a0, e_b0;

  always #5 clock = ~clock;

  register_file #(.WRITE_FIRST(1'b1)) u_wf (
    .clock(clock), .reset_n(rst_n), .clear_req(creq), .busy(busy_wf),
    .write_en(wen), .write_addr(wa), .data_in(din),
    .read_addr_a(ra), .data_out_a(da_wf), .read_addr_b(rb), .data_out_b(db_wf)
  );

  register_file #(.WRITE_FIRST(1'b0)) u_rf (
    .clock(clock), .reset_n(rst_n), .clear_req(creq), .busy(busy_rf),
    .write_en(wen), .write_addr(wa), .data_in(din),
    .read_addr_a(ra), .data_out_a(da_rf), .read_addr_b(rb), .data_out_b(db_rf)
  );

  register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .WRITE_FIRST(1'b1)) u_small (
    .clock(clock), .reset_n(rst_n), .clear_req(s_creq), .busy(s_busy),
    .write_en(s_we), .write_addr(s_wa), .data_in(s_din),
    .read_addr_a(s_ra), .data_out_a(s_da), .read_addr_b(s_rb), .data_out_b(s_db)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic       we;
    logic [7:0] oa, ob;
    if (clr_left > 0) begin
      e_a1 = '0; e_b1 = '0; e_a0 = '0; e_b0 = '0;
      clr_left--;
    end else begin
      we = wen && !creq;
      oa = m[ra];
      ob = m[rb];
      e_a0 = oa;
      e_b0 = ob;
      e_a1 = (we && wa == ra) ? din : oa;
      e_b1 = (we && wa == rb) ? din : ob;
      if (we) m[wa] = din;
      if (creq) begin
        clr_left = 256;
        foreach (m[i]) m[i] = '0;
      end
    end
    e_busy = (clr_left > 0);
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    check("busy_wf", busy_wf, e_busy);
    check("busy_rf", busy_rf, e_busy);
    check("a_wf", da_wf, e_a1);
    check("b_wf", db_wf, e_b1);
    check("a_rf", da_rf, e_a0);
    check("b_rf", db_rf, e_b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    clr_left = 256;
    foreach (m[i]) m[i] = '0;
    e_a1 = '0; e_b1 = '0; e_a0 = '0; e_b0 = '0; e_busy = 1'b1;
    check("rst_busy", busy_wf, 1);
    check("rst_a", da_wf, 0);
    check("rst_b", db_rf, 0);
    check("rst_s_busy", s_busy, 1);
    #2 rst_n = 1'b1;
  endtask

  task automatic run_until_idle(output int n);
    n = 0;
    while (busy_wf && n < 2000) begin
      step();
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    @(posedge clock);
    #1;
    do_reset();
    run_until_idle(n);
    check("reset_clear_len", n, 256);
    ra = 8'h00; rb = 8'hFF;
    step();
    check("post_clear_00", da_wf, 8'h00);
    check("post_clear_ff", db_wf, 8'h00);

    wen = 1; wa = 8'h10; din = 8'h5A; step();
    wen = 0; ra = 8'h10; rb = 8'h10; step();
    check("basic_a", da_wf, 8'h5A);
    check("basic_b", db_rf, 8'h5A);

    wen = 1; wa = 8'h20; din = 8'h11; step();
    din = 8'h22; ra = 8'h20; rb = 8'h20; step();
    check("rdw_new", da_wf, 8'h22);
    check("rdw_old", da_rf, 8'h11);
    wen = 0; step();
    check("rdw_after", db_rf, 8'h22);

    wen = 1; wa = 8'h01; din = 8'hAA; step();
    wa = 8'h02; din = 8'hBB; step();
    wa = 8'h03; din = 8'hCC; ra = 8'h01; rb = 8'h02; step();
    check("dual_a", da_wf, 8'hAA);
    check("dual_b", db_rf, 8'hBB);
    wen = 0; ra = 8'h03; step();
    check("dual_w", da_rf, 8'hCC);

    for (int i = 0; i < 256; i++) begin
      wen = 1; wa = 8'(i); din = 8'hFF; step();
    end
    creq = 1; wa = 8'h05; din = 8'h77; step();
    creq = 0; wen = 0;
    check("creq_busy_rise", busy_wf, 1);
    run_until_idle(n);
    check("creq_clear_len", n, 256);
    for (int i = 0; i < 256; i++) begin
      ra = 8'(i); rb = 8'(255 - i); step();
    end
    ra = 8'h05; step();
    check("dropped_write", da_wf, 8'h00);

    creq = 1; step();
    creq = 0;
    for (int i = 0; i < 100; i++) begin
      wen = 1; wa = 8'h40; din = 8'h33; step();
    end
    wen = 0;
    do_reset();
    run_until_idle(n);
    check("midreset_clear_len", n, 256);
    ra = 8'h40; step();
    check("clear_write_dropped", da_wf, 8'h00);

    for (int i = 0; i < 1500; i++) begin
      wen  = 1'($urandom);
      wa   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      ra   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      rb   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      din  = 8'($urandom);
      creq = ($urandom_range(0, 299) == 0);
      step();
    end
    creq = 0; wen = 0;
    run_until_idle(n);

    do_reset();
    n = 0;
    while (s_busy && n < 100) begin step(); n++; end
    check("s_reset_clear_len", n, 16);
    s_we = 1; s_wa = 4'hF; s_din = 16'hBEEF; step();
    s_we = 0; s_ra = 4'hF; s_rb = 4'h0; step();
    check("s_read_a", s_da, 16'hBEEF);
    check("s_read_b", s_db, 16'h0000);
    s_we = 1; s_wa = 4'h3; s_din = 16'h1234; s_ra = 4'h3; step();
    check("s_rdw", s_da, 16'h1234);
    s_we = 0; s_creq = 1; step();
    s_creq = 0;
    check("s_creq_busy", s_busy, 1);
    step();
    check("s_clear_out", s_da, 16'h0000);
    n = 1;
    while (s_busy && n < 100) begin step(); n++; end
    check("s_creq_clear_len", n, 16);
    s_ra = 4'hF; step();
    check("s_after_clear", s_da, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
